// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result checker: opcodes, opcode sweep order,
// FSM states and the operand LFSR step.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam int NUM_OPS = 6;

  // Opcode sweep order; vector k uses entry (k mod NUM_OPS).
  localparam logic [3:0] OP_TABLE [NUM_OPS] = '{ALU_AND, ALU_OR, ALU_ADD,
                                                 ALU_SUB, ALU_SLT, ALU_NOR};

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    CHECK,
    FINISH
  } state_t;

  function automatic logic [3:0] op_code(input logic [2:0] sel);
    logic [3:0] code;
    case (sel)
      3'd0:    code = OP_TABLE[0];
      3'd1:    code = OP_TABLE[1];
      3'd2:    code = OP_TABLE[2];
      3'd3:    code = OP_TABLE[3];
      3'd4:    code = OP_TABLE[4];
      3'd5:    code = OP_TABLE[5];
      default: code = OP_TABLE[0];
    endcase
    return code;
  endfunction

  // Fibonacci LFSR, taps 16/14/13/11, shifts left with feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the MIPS-style ALU; produces the result and
// zero flag the checker expects for the operands it is currently driving.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] alu_ctl,
  output logic [7:0] exp_out,
  output logic       exp_zero
);

  always_comb begin
    exp_out = 8'h00;
    case (alu_ctl)
      ALU_AND: exp_out = a & b;
      ALU_OR:  exp_out = a | b;
      ALU_ADD: exp_out = a + b;
      ALU_SUB: exp_out = a - b;
      ALU_SLT: exp_out = {7'b0, ($signed(a) < $signed(b))};
      ALU_NOR: exp_out = ~(a | b);
      default: exp_out = 8'h00;
    endcase
    exp_zero = (exp_out == 8'h00);
  end

endmodule

// File: rtl/alu_result_checker.sv
// Sweeps LFSR-generated operands across the opcode table into an external ALU,
// compares each response against alu_ref_model and tallies pass/fail counts.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int          NUM_VECTORS   = 48,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [3:0]  alu_ctl,
  input  logic [7:0]  alu_out,
  input  logic        zero,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pass_cnt,
  output logic [7:0]  fail_cnt,
  output logic [15:0] first_fail_idx
);

  localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  SETTLE_TC  = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0]  LAST_OP    = 3'(NUM_OPS - 1);
  localparam logic [15:0] NO_FAIL    = 16'hFFFF;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] index;
  logic [2:0]  op_sel;
  logic [3:0]  settle_cnt;
  logic [7:0]  out_q;
  logic        zero_q;
  logic        armed;

  logic [7:0]  exp_out;
  logic        exp_zero;
  logic [15:0] lfsr_nxt;
  logic [2:0]  op_sel_nxt;
  logic        vec_ok;

  alu_ref_model u_ref (
    .a        (a),
    .b        (b),
    .alu_ctl  (alu_ctl),
    .exp_out  (exp_out),
    .exp_zero (exp_zero)
  );

  always_comb begin
    lfsr_nxt   = lfsr_step(lfsr);
    op_sel_nxt = (op_sel == LAST_OP) ? 3'd0 : op_sel + 3'd1;
    vec_ok     = (out_q == exp_out) && (zero_q == exp_zero);
  end

  // armed stays low for the first edge after reset release so a start
  // coinciding with reset deassertion is not taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lfsr           <= LFSR_SEED;
      index          <= '0;
      op_sel         <= '0;
      settle_cnt     <= '0;
      out_q          <= '0;
      zero_q         <= 1'b0;
      armed          <= 1'b0;
      a              <= '0;
      b              <= '0;
      alu_ctl        <= ALU_AND;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= NO_FAIL;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (start && armed) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= NO_FAIL;
            lfsr           <= LFSR_SEED;
            index          <= '0;
            op_sel         <= '0;
            a              <= LFSR_SEED[15:8];
            b              <= LFSR_SEED[7:0];
            alu_ctl        <= op_code(3'd0);
            settle_cnt     <= SETTLE_TC;
            busy           <= 1'b1;
            done           <= 1'b0;
            state          <= DRIVE;
          end
        end

        DRIVE: begin
          if (settle_cnt == 4'd0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        SAMPLE: begin
          out_q  <= alu_out;
          zero_q <= zero;
          state  <= CHECK;
        end

        CHECK: begin
          if (vec_ok) begin
            if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
          end else begin
            if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
            if (first_fail_idx == NO_FAIL) first_fail_idx <= index;
          end
          lfsr   <= lfsr_nxt;
          index  <= index + 16'd1;
          op_sel <= op_sel_nxt;
          if (index == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            a          <= lfsr_nxt[15:8];
            b          <= lfsr_nxt[7:0];
            alu_ctl    <= op_code(op_sel_nxt);
            settle_cnt <= SETTLE_TC;
            state      <= DRIVE;
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 Parameter NUM_VECTORS, 48, number of test vectors per sweep; legal range 1..65534.
REQ-002 Parameter SETTLE_CYCLES, 1, cycles the ALU inputs are held before sampling; legal range 1..15.
REQ-003 Parameter LFSR_SEED, 16'hACE1, operand generator seed; must be nonzero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a sweep.
REQ-007 a  output  8  operand A driven to the ALU under test.
REQ-008 b  output  8  operand B driven to the ALU under test.
REQ-009 alu_ctl  output  4  opcode driven to the ALU under test.
REQ-010 alu_out  input  8  result returned by the ALU under test.
REQ-011 zero  input  1  zero flag returned by the ALU under test.
REQ-012 busy  output  1  high while a sweep is in progress.
REQ-013 done  output  1  high from sweep completion until the next accepted start or reset.
REQ-014 pass_cnt  output  8  count of matching vectors, saturating at 255.
REQ-015 fail_cnt  output  8  count of mismatching vectors, saturating at 255.
REQ-016 first_fail_idx  output  16  index of the first mismatching vector; 16'hFFFF when none.

Function
REQ-017 FSM states: IDLE, DRIVE, SAMPLE, CHECK, FINISH; IDLE on reset.
REQ-018 IDLE + start: clear counters, set first_fail_idx=FFFF, load LFSR with LFSR_SEED, index=0, deassert done, go DRIVE.
REQ-019 start while busy is ignored, with no effect on any state or output.
REQ-020 DRIVE: a=lfsr[15:8], b=lfsr[7:0], alu_ctl=op_table[index mod 6]; hold for exactly SETTLE_CYCLES cycles, then go SAMPLE.
REQ-021 op_table order: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-022 Expected results: ADD/SUB are modulo 256; SLT gives 8'h01 if signed a < signed b, else 8'h00; NOR is ~(a|b); expected zero = (expected result == 0).
REQ-023 SAMPLE: register alu_out and zero in one cycle, then go CHECK.
REQ-024 CHECK: a vector matches only if both result and zero equal their expected values; increment pass_cnt or fail_cnt accordingly, and on the first mismatch latch the current index into first_fail_idx.
REQ-025 CHECK: advance the LFSR one step (x^16+x^14+x^13+x^11+1, Fibonacci, shift left, feedback into bit 0), then index+1; go FINISH if index == NUM_VECTORS-1, else go DRIVE.
REQ-026 Per-vector latency is SETTLE_CYCLES+2 cycles; sweep length is NUM_VECTORS*(SETTLE_CYCLES+2) cycles.
REQ-027 FINISH: busy=0, done=1, then go IDLE; counters and first_fail_idx hold until the next accepted start.
REQ-028 a, b and alu_ctl stay stable from DRIVE entry through SAMPLE, and hold their last values in IDLE.
REQ-029 Counters saturate at 255 and never wrap.

Reset
REQ-030 reset asserted in any state, including mid-sweep: go IDLE; a=b=0; alu_ctl=0000; busy=0; done=0; pass_cnt=fail_cnt=0; first_fail_idx=FFFF; LFSR=LFSR_SEED; index=0.
REQ-031 No start is accepted during the cycle in which reset deasserts.

Structure
REQ-032 Shared package alu_pkg holds the opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR), the 6-entry op_table, and the FSM state enum.
REQ-033 The expected-result computation is a separate combinational sub-module, alu_ref_model (inputs a, b, alu_ctl; outputs exp_out, exp_zero).

Verification
REQ-034 Correct mipsALU connected, defaults, pulse start -> vector 0 drives a=AC, b=E1, alu_ctl=0000 (expected A0); at done: pass_cnt=48, fail_cnt=0, first_fail_idx=FFFF; done asserted 144 cycles after start.
REQ-035 ALU model with the zero flag inverted -> fail_cnt=48, pass_cnt=0, first_fail_idx=0000.
REQ-036 ALU model whose SLT compares unsigned, vectors forced to a=80, b=01 -> first failure at index 4 (expected 01, got 00).
REQ-037 start re-pulsed at cycle 20 of a sweep -> sweep continues unchanged; final counts equal the single-start run.
REQ-038 reset asserted during vector 10 -> next cycle busy=0, done=0, counters 0, first_fail_idx=FFFF; a fresh start reproduces REQ-034.
REQ-039 NUM_VECTORS=300, correct ALU -> pass_cnt=255 (saturated), fail_cnt=0, done after 900 cycles.
